// File: rtl/pdp8_trace.sv
// Instruction-trace monitor for the pdp8 core: counts instruction fetches, samples
// every Nth instruction into a ring buffer and offers a pop-style readout port.
module pdp8_trace #(
    parameter int DEPTH_LOG2   = 6,
    parameter int SAMPLE_W     = 16,
    parameter int CYCLE_W      = 32,
    parameter int STOP_ON_FULL = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            state,
    input  logic [11:0]           pc,
    input  logic [11:0]           mb,
    input  logic [11:0]           ac,
    input  logic                  l,
    input  logic                  ion,
    input  logic [2:0]            if_in,
    input  logic [2:0]            df_in,
    input  logic                  arm,
    input  logic                  clear,
    input  logic [SAMPLE_W-1:0]   sample_interval,
    input  logic [CYCLE_W-1:0]    max_cycles,
    input  logic                  rd_en,
    output logic [43:0]           rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  running,
    output logic                  halted,
    output logic                  limit_hit,
    output logic                  overflow,
    output logic [11:0]           halt_pc,
    output logic [CYCLE_W-1:0]    instr_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] ST_F0   = 4'b0000;
    localparam logic [3:0] ST_HALT = 4'b1100;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPED} fsm_t;

    fsm_t                  fsm_q, fsm_d;
    logic                  prev_f0_q, prev_f0_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [SAMPLE_W-1:0]   sample_cnt_q, sample_cnt_d;
    logic [CYCLE_W-1:0]    instr_count_q, instr_count_d;
    logic                  halted_q, halted_d, limit_hit_q, limit_hit_d;
    logic                  overflow_q, overflow_d;
    logic [11:0]           halt_pc_q, halt_pc_d;
    logic [43:0]           rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [43:0]           mem_q [DEPTH];

    logic                  boundary, pop, full, grow, wr_en;
    logic [CYCLE_W-1:0]    instr_inc;
    logic [SAMPLE_W-1:0]   interval_eff, sample_inc;
    logic [43:0]           wr_data;

    assign boundary     = (state == ST_F0) && !prev_f0_q;
    assign pop          = rd_en && (count_q != '0);
    assign full         = (count_q == CNT_FULL);
    assign instr_inc    = (&instr_count_q) ? instr_count_q : instr_count_q + CYCLE_W'(1);
    assign interval_eff = (sample_interval == '0) ? SAMPLE_W'(1) : sample_interval;
    assign sample_inc   = sample_cnt_q + SAMPLE_W'(1);
    assign wr_data      = {pc, mb, ac, l, if_in, df_in, ion};

    always_comb begin
        fsm_d         = fsm_q;
        prev_f0_d     = (state == ST_F0);
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        sample_cnt_d  = sample_cnt_q;
        instr_count_d = instr_count_q;
        halted_d      = halted_q;
        limit_hit_d   = limit_hit_q;
        overflow_d    = overflow_q;
        halt_pc_d     = halt_pc_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = 1'b0;
        grow          = 1'b0;
        wr_en         = 1'b0;

        if (clear) begin
            fsm_d       = S_IDLE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            halted_d    = 1'b0;
            limit_hit_d = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            if (pop) begin
                rd_data_d  = mem_q[rd_ptr_q];
                rd_valid_d = 1'b1;
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
            end

            unique case (fsm_q)
                S_IDLE, S_STOPPED: begin
                    if (arm) begin
                        fsm_d         = S_RUN;
                        instr_count_d = '0;
                        sample_cnt_d  = '0;
                        halted_d      = 1'b0;
                        limit_hit_d   = 1'b0;
                        overflow_d    = 1'b0;
                    end
                end
                S_RUN: begin
                    if (state == ST_HALT) begin
                        halted_d  = 1'b1;
                        halt_pc_d = pc;
                        fsm_d     = S_STOPPED;
                    end else if (boundary) begin
                        instr_count_d = instr_inc;
                        sample_cnt_d  = (sample_inc >= interval_eff) ? '0 : sample_inc;
                        if ((max_cycles != '0) && (instr_inc == max_cycles)) begin
                            limit_hit_d = 1'b1;
                            fsm_d       = S_STOPPED;
                        end else if (sample_cnt_q == '0) begin
                            // A pop in the same cycle frees the slot, so only full-without-pop is an overflow.
                            if (full && !pop) begin
                                overflow_d = 1'b1;
                                if (STOP_ON_FULL != 0) begin
                                    fsm_d = S_STOPPED;
                                end else begin
                                    wr_en    = 1'b1;
                                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                                end
                            end else begin
                                wr_en    = 1'b1;
                                grow     = 1'b1;
                                wr_ptr_d = wr_ptr_q + PTR_ONE;
                            end
                        end
                    end
                end
                default: fsm_d = S_IDLE;
            endcase

            unique case ({grow, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q         <= S_IDLE;
            prev_f0_q     <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            sample_cnt_q  <= '0;
            instr_count_q <= '0;
            halted_q      <= 1'b0;
            limit_hit_q   <= 1'b0;
            overflow_q    <= 1'b0;
            halt_pc_q     <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            prev_f0_q     <= prev_f0_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            sample_cnt_q  <= sample_cnt_d;
            instr_count_q <= instr_count_d;
            halted_q      <= halted_d;
            limit_hit_q   <= limit_hit_d;
            overflow_q    <= overflow_d;
            halt_pc_q     <= halt_pc_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    // NOTE: the storage array has no reset; zeroed pointers and count already make it empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign count       = count_q;
    assign running     = (fsm_q == S_RUN);
    assign halted      = halted_q;
    assign limit_hit   = limit_hit_q;
    assign overflow    = overflow_q;
    assign halt_pc     = halt_pc_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_pdp8_trace.sv
// Directed bench for pdp8_trace: a deep instance for capture/interval/limit/halt and two
// 4-entry instances (overwrite and stop-on-full) sharing the same CPU stimulus.
module tb_pdp8_trace;

    localparam logic [3:0] F0 = 4'b0000, HALT = 4'b1100, EXEC = 4'b0010;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  state;
    logic [11:0] pc, mb, ac;
    logic        l, ion, arm, clear, rd_en;
    logic [2:0]  if_in, df_in;
    logic [15:0] sample_interval;
    logic [31:0] max_cycles;

    logic [43:0] b_rd_data, a_rd_data, s_rd_data;
    logic        b_rd_valid, a_rd_valid, s_rd_valid;
    logic [7:0]  b_count;
    logic [2:0]  a_count, s_count;
    logic        b_running, a_running, s_running;
    logic        b_halted, a_halted, s_halted;
    logic        b_limit_hit, a_limit_hit, s_limit_hit;
    logic        b_overflow, a_overflow, s_overflow;
    logic [11:0] b_halt_pc, a_halt_pc, s_halt_pc;
    logic [31:0] b_instr_count, a_instr_count, s_instr_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pdp8_trace #(.DEPTH_LOG2(7), .STOP_ON_FULL(0)) u_big (
        .clk(clk), .reset(reset), .state(state), .pc(pc), .mb(mb), .ac(ac), .l(l), .ion(ion),
        .if_in(if_in), .df_in(df_in), .arm(arm), .clear(clear), .sample_interval(sample_interval),
        .max_cycles(max_cycles), .rd_en(rd_en), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .count(b_count), .running(b_running), .halted(b_halted), .limit_hit(b_limit_hit),
        .overflow(b_overflow), .halt_pc(b_halt_pc), .instr_count(b_instr_count));

    pdp8_trace #(.DEPTH_LOG2(2), .STOP_ON_FULL(0)) u_wrap (
        .clk(clk), .reset(reset), .state(state), .pc(pc), .mb(mb), .ac(ac), .l(l), .ion(ion),
        .if_in(if_in), .df_in(df_in), .arm(arm), .clear(clear), .sample_interval(sample_interval),
        .max_cycles(max_cycles), .rd_en(rd_en), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .count(a_count), .running(a_running), .halted(a_halted), .limit_hit(a_limit_hit),
        .overflow(a_overflow), .halt_pc(a_halt_pc), .instr_count(a_instr_count));

    pdp8_trace #(.DEPTH_LOG2(2), .STOP_ON_FULL(1)) u_stop (
        .clk(clk), .reset(reset), .state(state), .pc(pc), .mb(mb), .ac(ac), .l(l), .ion(ion),
        .if_in(if_in), .df_in(df_in), .arm(arm), .clear(clear), .sample_interval(sample_interval),
        .max_cycles(max_cycles), .rd_en(rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
        .count(s_count), .running(s_running), .halted(s_halted), .limit_hit(s_limit_hit),
        .overflow(s_overflow), .halt_pc(s_halt_pc), .instr_count(s_instr_count));

    // Side fields are derived from the PC so each entry carries distinct L/IF/DF/ION bits.
    function automatic logic [43:0] entry(input logic [11:0] p, input logic [11:0] ir, input logic [11:0] a);
        return {p, ir, a, p[0], p[4:2], p[7:5], p[1]};
    endfunction

    task automatic instr(input logic [11:0] p, input logic [11:0] ir, input logic [11:0] a);
        @(negedge clk);
        state = F0; pc = p; mb = ir; ac = a;
        l = p[0]; if_in = p[4:2]; df_in = p[7:5]; ion = p[1];
        @(negedge clk);
        state = EXEC;
    endtask

    task automatic pulse_arm();
        @(negedge clk); arm = 1'b1;
        @(negedge clk); arm = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk); rd_en = 1'b1;
        @(negedge clk); rd_en = 1'b0;
    endtask

    task automatic test_reset();
        vectors++; if ({b_rd_data, b_rd_valid, b_count, b_running, b_halted, b_limit_hit, b_overflow, b_halt_pc, b_instr_count} !== '0) begin
            miscompares++; $display("FAIL reset_outputs: got nonzero outputs count=%0d running=%0d instr_count=%0d", b_count, b_running, b_instr_count); end
        vectors++; if ({a_count, s_count, a_running, s_running} !== '0) begin
            miscompares++; $display("FAIL reset_small: got a_count=%0d s_count=%0d want 0", a_count, s_count); end
    endtask

    task automatic test_basic_capture();
        sample_interval = 16'd1; max_cycles = 32'd0;
        pulse_clear(); pulse_arm();
        vectors++; if (b_running !== 1'b1) begin miscompares++; $display("FAIL arm_running: got %0d want 1", b_running); end
        for (int i = 0; i < 5; i++) instr(12'o200 + 12'(i), 12'o1000 + 12'(i), 12'(i * 7 + 1));
        vectors++; if (b_count !== 8'd5) begin miscompares++; $display("FAIL basic_count: got %0d want 5", b_count); end
        vectors++; if (b_instr_count !== 32'd5) begin miscompares++; $display("FAIL basic_instr_count: got %0d want 5", b_instr_count); end
        for (int i = 0; i < 5; i++) begin
            pop_one();
            vectors++; if (b_rd_valid !== 1'b1) begin miscompares++; $display("FAIL basic_rd_valid[%0d]: got %0d want 1", i, b_rd_valid); end
            vectors++; if (b_rd_data !== entry(12'o200 + 12'(i), 12'o1000 + 12'(i), 12'(i * 7 + 1))) begin
                miscompares++; $display("FAIL basic_rd_data[%0d]: got %h want %h", i, b_rd_data, entry(12'o200 + 12'(i), 12'o1000 + 12'(i), 12'(i * 7 + 1))); end
        end
        @(negedge clk);
        vectors++; if (b_rd_valid !== 1'b0) begin miscompares++; $display("FAIL rd_valid_pulse: got %0d want 0", b_rd_valid); end
        pop_one();
        vectors++; if (b_rd_valid !== 1'b0) begin miscompares++; $display("FAIL empty_read_valid: got %0d want 0", b_rd_valid); end
        vectors++; if (b_count !== 8'd0) begin miscompares++; $display("FAIL empty_read_count: got %0d want 0", b_count); end
    endtask

    task automatic test_interval();
        pulse_clear();
        sample_interval = 16'd3;
        pulse_arm();
        for (int i = 0; i < 10; i++) instr(12'o300 + 12'(i), 12'o7001, 12'(i));
        vectors++; if (b_count !== 8'd4) begin miscompares++; $display("FAIL interval_count: got %0d want 4", b_count); end
        vectors++; if (b_instr_count !== 32'd10) begin miscompares++; $display("FAIL interval_instr_count: got %0d want 10", b_instr_count); end
        for (int k = 0; k < 4; k++) begin
            pop_one();
            vectors++; if (b_rd_data[43:32] !== 12'o300 + 12'(3 * k)) begin
                miscompares++; $display("FAIL interval_pc[%0d]: got %o want %o", k, b_rd_data[43:32], 12'o300 + 12'(3 * k)); end
        end
        sample_interval = 16'd1;
    endtask

    task automatic test_limit();
        pulse_clear();
        max_cycles = 32'd100;
        pulse_arm();
        for (int i = 0; i < 100; i++) instr(12'(i), 12'o7000, 12'o0);
        vectors++; if (b_limit_hit !== 1'b1) begin miscompares++; $display("FAIL limit_hit: got %0d want 1", b_limit_hit); end
        vectors++; if (b_running !== 1'b0) begin miscompares++; $display("FAIL limit_running: got %0d want 0", b_running); end
        vectors++; if (b_instr_count !== 32'd100) begin miscompares++; $display("FAIL limit_instr_count: got %0d want 100", b_instr_count); end
        vectors++; if (b_count !== 8'd99) begin miscompares++; $display("FAIL limit_count: got %0d want 99", b_count); end
        instr(12'o777, 12'o7000, 12'o0);
        vectors++; if (b_instr_count !== 32'd100 || b_count !== 8'd99) begin
            miscompares++; $display("FAIL limit_after: got instr_count=%0d count=%0d want 100/99", b_instr_count, b_count); end
        max_cycles = 32'd0;
    endtask

    task automatic test_halt();
        pulse_clear(); pulse_arm();
        instr(12'o205, 12'o7200, 12'o1);
        instr(12'o206, 12'o7300, 12'o2);
        @(negedge clk); state = HALT; pc = 12'o207;
        @(negedge clk); state = EXEC; pc = 12'o0;
        vectors++; if (b_halted !== 1'b1) begin miscompares++; $display("FAIL halt_flag: got %0d want 1", b_halted); end
        vectors++; if (b_halt_pc !== 12'o207) begin miscompares++; $display("FAIL halt_pc: got %o want 207", b_halt_pc); end
        vectors++; if (b_running !== 1'b0) begin miscompares++; $display("FAIL halt_running: got %0d want 0", b_running); end
        vectors++; if (b_count !== 8'd2 || b_instr_count !== 32'd2) begin
            miscompares++; $display("FAIL halt_count: got count=%0d instr_count=%0d want 2/2", b_count, b_instr_count); end
    endtask

    task automatic test_overflow();
        pulse_clear(); pulse_arm();
        for (int i = 1; i <= 6; i++) instr(12'(i), 12'o7000, 12'(i));
        vectors++; if (a_count !== 3'd4 || a_overflow !== 1'b1 || a_running !== 1'b1) begin
            miscompares++; $display("FAIL wrap_status: got count=%0d overflow=%0d running=%0d want 4/1/1", a_count, a_overflow, a_running); end
        vectors++; if (s_count !== 3'd4 || s_overflow !== 1'b1 || s_running !== 1'b0) begin
            miscompares++; $display("FAIL stop_status: got count=%0d overflow=%0d running=%0d want 4/1/0", s_count, s_overflow, s_running); end
        for (int k = 0; k < 4; k++) begin
            pop_one();
            vectors++; if (a_rd_data[43:32] !== 12'(3 + k)) begin
                miscompares++; $display("FAIL wrap_pop[%0d]: got %0d want %0d", k, a_rd_data[43:32], 3 + k); end
            vectors++; if (s_rd_data[43:32] !== 12'(1 + k)) begin
                miscompares++; $display("FAIL stop_pop[%0d]: got %0d want %0d", k, s_rd_data[43:32], 1 + k); end
        end
    endtask

    task automatic test_full_read_write();
        pulse_clear(); pulse_arm();
        for (int i = 0; i < 4; i++) instr(12'o10 + 12'(i), 12'o7000, 12'o0);
        vectors++; if (a_count !== 3'd4 || s_count !== 3'd4 || a_overflow !== 1'b0 || s_overflow !== 1'b0) begin
            miscompares++; $display("FAIL full_pre: got a=%0d/%0d s=%0d/%0d want 4/0", a_count, a_overflow, s_count, s_overflow); end
        @(negedge clk);
        state = F0; pc = 12'o14; mb = 12'o7000; ac = 12'o0; rd_en = 1'b1;
        l = 1'b0; if_in = 3'd3; df_in = 3'd0; ion = 1'b0;
        @(negedge clk);
        state = EXEC; rd_en = 1'b0;
        vectors++; if (a_rd_valid !== 1'b1 || a_rd_data[43:32] !== 12'o10) begin
            miscompares++; $display("FAIL rw_wrap_pop: got valid=%0d pc=%o want 1/10", a_rd_valid, a_rd_data[43:32]); end
        vectors++; if (s_rd_valid !== 1'b1 || s_rd_data[43:32] !== 12'o10) begin
            miscompares++; $display("FAIL rw_stop_pop: got valid=%0d pc=%o want 1/10", s_rd_valid, s_rd_data[43:32]); end
        vectors++; if (a_count !== 3'd4 || a_overflow !== 1'b0) begin
            miscompares++; $display("FAIL rw_wrap_status: got count=%0d overflow=%0d want 4/0", a_count, a_overflow); end
        vectors++; if (s_count !== 3'd4 || s_overflow !== 1'b0 || s_running !== 1'b1) begin
            miscompares++; $display("FAIL rw_stop_status: got count=%0d overflow=%0d running=%0d want 4/0/1", s_count, s_overflow, s_running); end
        for (int k = 0; k < 4; k++) begin
            pop_one();
            vectors++; if (a_rd_data[43:32] !== 12'o11 + 12'(k) || s_rd_data[43:32] !== 12'o11 + 12'(k)) begin
                miscompares++; $display("FAIL rw_drain[%0d]: got a=%o s=%o want %o", k, a_rd_data[43:32], s_rd_data[43:32], 12'o11 + 12'(k)); end
        end
    endtask

    task automatic test_clear_arm();
        instr(12'o20, 12'o7000, 12'o0);
        instr(12'o21, 12'o7000, 12'o0);
        vectors++; if (a_count !== 3'd2) begin miscompares++; $display("FAIL clear_pre: got %0d want 2", a_count); end
        @(negedge clk); clear = 1'b1; arm = 1'b1;
        @(negedge clk); clear = 1'b0; arm = 1'b0;
        vectors++; if (a_count !== 3'd0 || a_running !== 1'b0 || b_count !== 8'd0 || b_running !== 1'b0) begin
            miscompares++; $display("FAIL clear_arm: got a=%0d/%0d b=%0d/%0d want count 0 running 0", a_count, a_running, b_count, b_running); end
        vectors++; if (b_halted !== 1'b0 || a_overflow !== 1'b0) begin
            miscompares++; $display("FAIL clear_flags: got halted=%0d overflow=%0d want 0/0", b_halted, a_overflow); end
        instr(12'o22, 12'o7000, 12'o0);
        vectors++; if (b_count !== 8'd0) begin miscompares++; $display("FAIL idle_no_capture: got %0d want 0", b_count); end
    endtask

    task automatic test_async_reset();
        pulse_arm();
        instr(12'o30, 12'o7000, 12'o0);
        instr(12'o31, 12'o7000, 12'o0);
        vectors++; if (b_count !== 8'd2) begin miscompares++; $display("FAIL areset_pre: got %0d want 2", b_count); end
        #2 reset = 1'b0;
        #1;
        vectors++; if (b_count !== 8'd0 || b_running !== 1'b0 || b_instr_count !== 32'd0) begin
            miscompares++; $display("FAIL areset: got count=%0d running=%0d instr_count=%0d want 0", b_count, b_running, b_instr_count); end
        @(negedge clk); reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        state = EXEC; pc = '0; mb = '0; ac = '0; l = 1'b0; ion = 1'b0; if_in = '0; df_in = '0;
        arm = 1'b0; clear = 1'b0; rd_en = 1'b0;
        sample_interval = 16'd1; max_cycles = 32'd0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b1;
        test_basic_capture();
        test_interval();
        test_limit();
        test_halt();
        test_overflow();
        test_full_read_write();
        test_clear_arm();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pdp8_trace.md
# pdp8_trace

Parametrised hardware instruction-trace monitor for the pdp8 core. It watches the CPU major-state bus and architectural registers, and counts instruction fetches. It captures every Nth instruction's PC/IR/AC/L/IF/DF/ION into a ring buffer, stops on a HALT state or on a programmable instruction limit, and exposes a pop-style readout port. It sits beside `pdp8` on the top level and is read by the front panel or a debug UART path.

## Interface
- DEPTH_LOG2, 6: buffer holds 2^DEPTH_LOG2 entries.
- SAMPLE_W, 16: width of the sample-interval register and counter.
- CYCLE_W, 32: width of the instruction counter and limit.
- STOP_ON_FULL, 0: 0 = ring overwrites oldest entry; 1 = stop when full.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- state  in  4  CPU major state; 4'b0000 = F0, 4'b1100 = HALT.
- pc, mb, ac  in  12 each  CPU PC, memory buffer (IR at F0), accumulator.
- l, ion  in  1 each  link, interrupt enable.
- if_in, df_in  in  3 each  instruction/data field.
- arm  in  1  pulse; start a trace run.
- clear  in  1  pulse; abort and empty the buffer.
- sample_interval  in  SAMPLE_W  capture every Nth instruction; 0 is treated as 1.
- max_cycles  in  CYCLE_W  instruction limit; 0 = unlimited.
- rd_en  in  1  pop the oldest entry.
- rd_data  out  44  {pc, ir, ac, l, if, df, ion}, MSB first.
- rd_valid  out  1  rd_data valid this cycle.
- count  out  DEPTH_LOG2+1  entries held.
- running, halted, limit_hit, overflow  out  1 each  status flags.
- halt_pc  out  12  PC at HALT.
- instr_count  out  CYCLE_W  instructions counted this run.

## Operation
- FSM states:
  - IDLE → RUN on `arm`. Entering RUN zeroes instr_count, the sample counter, halted, limit_hit and overflow. The buffer is not emptied.
  - RUN → STOPPED on HALT, on the instruction limit, or when full with STOP_ON_FULL=1.
  - STOPPED → RUN on `arm`.
  - Any state → IDLE on `clear`. `clear` also empties the buffer and zeroes all flags. `clear` wins over `arm` in the same cycle.
- Instruction boundary: a cycle with state==F0 whose previous-cycle state was not F0. Boundaries are counted only in RUN.
- Sampling: the boundary is captured when sample_cnt==0. sample_cnt then increments and wraps to 0 at max(sample_interval,1). The first boundary after `arm` is always captured.
- instr_count increments on every boundary and saturates at all-ones.
- Limit: if max_cycles≠0 and the post-increment instr_count == max_cycles:
  - set limit_hit and go to STOPPED;
  - that boundary is counted but not captured.
- HALT: state==4'b1100 in RUN sets halted, loads halt_pc=pc and goes to STOPPED. HALT is not a boundary.
- Full buffer, STOP_ON_FULL=0: the write overwrites the oldest entry, rd_ptr advances, overflow is set and stays set, count stays at max.
- Full buffer, STOP_ON_FULL=1: the capture is dropped, overflow is set, and the FSM goes to STOPPED.
- Read: `rd_en` with count≠0 pops rd_ptr. Reads are allowed in every state.
- Read on empty: ignored; rd_valid stays 0.
- Simultaneous read and write:
  - full: the read returns the oldest entry, the write proceeds, count is unchanged, overflow is not set;
  - empty: the read is ignored and the write proceeds.
- Pointers wrap modulo 2^DEPTH_LOG2.

## Timing
- Reset values: FSM=IDLE, all pointers and counters 0, every output 0.
- Capture takes fields from the boundary cycle. The entry is written at the closing clock edge, and count/instr_count update on that edge (visible the next cycle).
- rd_data/rd_valid are registered and appear the cycle after `rd_en`. rd_valid is a one-cycle pulse per pop.
- The status flags and the FSM change on the edge that closes the triggering cycle.
- `arm`/`clear` are sampled each edge. Holding `arm` in RUN has no effect.
- Async reset mid-run discards the buffer contents and all status immediately.

## Test plan
- Arm with interval=1 and max=0, then run 5 instructions at PC 0200–0204: count=5. Pops return PCs 0200..0204 in order with their IR and AC, one rd_valid each.
- Interval=3, 10 boundaries: the instructions at positions 0, 3, 6 and 9 are captured, count=4, instr_count=10.
- max_cycles=100: STOPPED on the 100th boundary, limit_hit=1, instr_count=100, count=99. A 101st F0 is ignored.
- HALT at PC 0207 in RUN: halted=1, halt_pc=0207, running=0. No entry is written for the HALT cycle.
- DEPTH_LOG2=2, STOP_ON_FULL=0, 6 captures of PCs 1–6: count=4, overflow=1, pops give 3,4,5,6. Repeat with STOP_ON_FULL=1: pops give 1,2,3,4 and the FSM is STOPPED.
- Full buffer with rd_en coinciding with a capture: count stays 4, overflow stays 0, and the popped value is the oldest entry. Then `clear` together with `arm`: IDLE, count=0.
